endecoder_stream_ctrl: RTL
==========================

# endecoder_stream_ctrl

Byte-stream initiator for the 4-bit round-based encrypt/decrypt engine (`EnDecoder`). It accepts 8-bit bytes over a valid/ready interface and splits each byte into two nibbles. It drives each nibble through the engine's start/done handshake, low nibble first, and reassembles the results into an output byte on a second valid/ready interface. A watchdog flags an engine that never answers.

## Interface
- `TIMEOUT`, default 24: maximum cycles waited for `ed_done_i` after a start pulse. Must be ≥ 17.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `mode_i`  in  1  0 = encrypt, 1 = decrypt. Sampled on byte accept.
- `key_i`  in  4  round key and round count. Sampled on byte accept.
- `in_data_i`  in  8  input byte.
- `in_valid_i`  in  1  input byte valid.
- `in_ready_o`  out  1  controller can accept a byte.
- `out_data_o`  out  8  result byte. `{hi_result, lo_result}`.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts the result.
- `ed_code_o`  out  4  nibble to the engine.
- `ed_key_o`  out  4  key to the engine.
- `ed_mode_o`  out  1  mode to the engine.
- `ed_start_o`  out  1  engine start pulse.
- `ed_code_i`  in  4  engine result.
- `ed_done_i`  in  1  engine done pulse.
- `busy_o`  out  1  high in any state other than IDLE and ERR.
- `error_o`  out  1  sticky watchdog error.

## Operation
- States: IDLE, START_LO, WAIT_LO, START_HI, WAIT_HI, OUT, ERR.
- **IDLE**
  - `in_ready_o` = 1.
  - On `in_valid_i & in_ready_o`: register the byte, `mode_i`, and `key_i`, then go to START_LO.
- **START_LO**
  - `ed_code_o` = byte[3:0].
  - `ed_start_o` = 1 for exactly this one cycle.
  - Clear the watchdog counter. Go to WAIT_LO.
- **WAIT_LO**
  - Counter increments each cycle.
  - On `ed_done_i`: capture `ed_code_i` as lo_result and go to START_HI.
  - If the counter reaches `TIMEOUT` with no done: go to ERR.
- **START_HI / WAIT_HI**
  - Same as START_LO / WAIT_LO, using byte[7:4] and capturing hi_result.
  - On done: go to OUT.
- **OUT**
  - `out_valid_o` = 1 and `out_data_o` is held stable until `out_ready_i`.
  - On `out_valid_o & out_ready_i`: go to IDLE.
- **ERR**
  - `error_o` = 1. `in_ready_o`, `out_valid_o`, and `ed_start_o` are all 0.
  - Leaves ERR only on reset.
- `ed_key_o` and `ed_mode_o` are registered copies of the sampled key and mode. They stay constant from START_LO through WAIT_HI, because the engine uses them on every round.
- `ed_code_o` holds its value between starts.
- `ed_done_i` is ignored outside WAIT_LO and WAIT_HI.
- Engine round count N = key when key ≠ 0. N = 16 when key = 0, since the engine's counter wraps.
- Input changes during processing have no effect. `key_i` and `mode_i` are only sampled at accept.

## Timing
- Reset values, all outputs 0:
  - `in_ready_o` is 0 during reset and 1 in IDLE after reset deasserts.
  - `out_data_o` = 0x00, `out_valid_o` = 0, `ed_*_o` = 0, `busy_o` = 0, `error_o` = 0, state = IDLE.
- Reset asserted mid-operation aborts immediately, with no output.
  - The engine shares the same reset at system level.
- Let byte accept occur at the edge ending cycle a.
  - `ed_start_o` is high in cycle a+1.
  - The engine's done for the low nibble is seen in cycle a+N+2.
  - START_HI is in cycle a+N+3.
  - The done for the high nibble is seen in cycle a+2N+4.
  - `out_valid_o` rises in cycle a+2N+5.
- A new byte can be accepted no earlier than the cycle after the OUT handshake, because `in_ready_o` is only high in IDLE.
- The watchdog trips `TIMEOUT` cycles after the start cycle. `error_o` rises the following cycle.

## Test plan
- **Encrypt, key 1:** encrypt, key 0x1, send byte 0x53.
  - Required: `out_data_o` = 0xE7.
  - Required: `out_valid_o` rises 7 cycles after the accept cycle.
  - Required: exactly two one-cycle `ed_start_o` pulses, with `ed_code_o` = 0x3 then 0x5.
- **Decrypt, key 1:** decrypt, key 0x1, send 0xE7.
  - Required: `out_data_o` = 0x53 (round trip).
- **Key 0:** key 0x0, any byte.
  - Required: each nibble takes 16 rounds and `out_valid_o` rises 37 cycles after accept.
  - Required: `error_o` stays 0 with `TIMEOUT` = 24.
- **Backpressure:** hold `out_ready_i` = 0 for 10 cycles in OUT, and change `in_data_i`, `key_i`, and `mode_i` meanwhile.
  - Required: `out_data_o` stays stable, `in_ready_o` stays 0, and the byte is released on the first `out_ready_i` cycle.
- **Watchdog:** tie `ed_done_i` = 0.
  - Required: `error_o` = 1 exactly `TIMEOUT`+1 cycles after START_LO.
  - Required: `in_ready_o` and `out_valid_o` = 0 until reset.
  - Required: after deasserting `rst_ni`, normal operation resumes.
- **Reset mid-operation:** assert `rst_ni` = 0 during WAIT_HI.
  - Required: all outputs 0 immediately, no `out_valid_o`, and the next byte is processed correctly.

Source files
------------

// File: rtl/endecoder_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// endecoder_stream_ctrl_if
//
// Purpose: groups every non-clock signal of the byte-stream controller in one
// bundle: the byte input stream, the result output stream, the nibble-level
// start/done link to the EnDecoder engine and the two status flags.
//
// Handshake rules (both byte streams):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. Once the producer raises valid, it keeps valid high and the payload
//   stable until that transfer edge. The producer never waits for ready before
//   raising valid. Ready may rise and fall freely while valid is low.
//   The engine link is not valid/ready. The controller issues a one-cycle
//   ed_start_o with code/key/mode. The engine replies with a one-cycle
//   ed_done_i, and ed_code_i carries the result during that cycle.
//
// Signals (directions seen from the controller, modport master):
//   mode_i       in   0 = encrypt, 1 = decrypt, sampled on byte accept
//   key_i[3:0]   in   round key / round count, sampled on byte accept
//   in_data_i    in   input byte
//   in_valid_i   in   input byte valid
//   in_ready_o   out  controller can take a byte
//   out_data_o   out  result byte {hi_result, lo_result}
//   out_valid_o  out  result valid
//   out_ready_i  in   consumer takes the result
//   ed_code_o    out  nibble to the engine
//   ed_key_o     out  key to the engine
//   ed_mode_o    out  mode to the engine
//   ed_start_o   out  engine start pulse
//   ed_code_i    in   engine result nibble
//   ed_done_i    in   engine done pulse
//   busy_o       out  controller is processing a byte
//   error_o      out  sticky watchdog error
// -----------------------------------------------------------------------------
interface endecoder_stream_ctrl_if;
   logic       mode_i;
   logic [3:0] key_i;
   logic [7:0] in_data_i;
   logic       in_valid_i;
   logic       in_ready_o;
   logic [7:0] out_data_o;
   logic       out_valid_o;
   logic       out_ready_i;
   logic [3:0] ed_code_o;
   logic [3:0] ed_key_o;
   logic       ed_mode_o;
   logic       ed_start_o;
   logic [3:0] ed_code_i;
   logic       ed_done_i;
   logic       busy_o;
   logic       error_o;

   // Controller side
   modport master (
      input  mode_i, key_i, in_data_i, in_valid_i, out_ready_i,
             ed_code_i, ed_done_i,
      output in_ready_o, out_data_o, out_valid_o,
             ed_code_o, ed_key_o, ed_mode_o, ed_start_o,
             busy_o, error_o
   );

   // Environment side: byte source, byte sink and engine
   modport slave (
      output mode_i, key_i, in_data_i, in_valid_i, out_ready_i,
             ed_code_i, ed_done_i,
      input  in_ready_o, out_data_o, out_valid_o,
             ed_code_o, ed_key_o, ed_mode_o, ed_start_o,
             busy_o, error_o
   );
endinterface

// File: rtl/endecoder_stream_ctrl.sv
// -----------------------------------------------------------------------------
// endecoder_stream_ctrl
//
// Purpose: byte-stream initiator for the 4-bit round-based EnDecoder engine.
// The controller accepts one byte and sends its low nibble, then its high
// nibble, through the engine start/done handshake. It returns {hi, lo} results
// as one byte. A watchdog moves the controller into a sticky error state when
// the engine does not answer within TIMEOUT cycles of a start pulse.
//
// Parameters:
//   TIMEOUT  cycles waited for ed_done_i after a start pulse. It must be at
//            least 17: the engine needs up to 16 rounds, and done arrives
//            N+1 cycles after start.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset (shared with the engine)
//   bus      endecoder_stream_ctrl_if.master, all stream/engine/status signals
//   state_o  current FSM state encoding, for debug and checker binding
//            0 IDLE, 1 START_LO, 2 WAIT_LO, 3 START_HI, 4 WAIT_HI, 5 OUT, 6 ERR
// -----------------------------------------------------------------------------
module endecoder_stream_ctrl #(
   parameter int unsigned TIMEOUT = 24
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   endecoder_stream_ctrl_if.master    bus,
   output logic [2:0]                 state_o
);

   // Wide enough to hold TIMEOUT itself
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_START_LO = 3'd1,
      S_WAIT_LO  = 3'd2,
      S_START_HI = 3'd3,
      S_WAIT_HI  = 3'd4,
      S_OUT      = 3'd5,
      S_ERR      = 3'd6
   } state_e;

   state_e             state_q;
   state_e             state_d;

   logic [3:0]         hi_nib_q;    // high nibble kept until START_HI
   logic [3:0]         code_q;      // nibble presented to the engine
   logic [3:0]         key_q;
   logic               mode_q;
   logic [3:0]         lo_res_q;
   logic [3:0]         hi_res_q;
   logic [CNT_W-1:0]   wd_q;

   logic               accept;
   logic               in_wait;
   logic               in_start;
   logic               wd_expired;

   // ---------------------------------------------------------------------------
   // Decodes shared by the FSM, the datapath and the watchdog
   // ---------------------------------------------------------------------------
   assign in_start = (state_q == S_START_LO) || (state_q == S_START_HI);
   assign in_wait  = (state_q == S_WAIT_LO)  || (state_q == S_WAIT_HI);

   // The counter is cleared in the start cycle, so in the k-th wait cycle it
   // holds k-1. Expiring at TIMEOUT-1 ends the TIMEOUT-th cycle after start,
   // and ERR (error_o) shows up one cycle later.
   assign wd_expired = (wd_q == CNT_W'(TIMEOUT - 1));

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d          = state_q;
      accept           = 1'b0;
      bus.in_ready_o   = 1'b0;
      bus.out_valid_o  = 1'b0;
      bus.ed_start_o   = 1'b0;
      bus.busy_o       = 1'b0;
      bus.error_o      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // The state register already reads IDLE while reset is held.
            // Gating with rst_ni keeps ready low until reset is released.
            bus.in_ready_o = rst_ni;
            accept         = bus.in_valid_i && rst_ni;
            if (accept) begin
               state_d = S_START_LO;
            end
         end

         S_START_LO: begin
            bus.ed_start_o = 1'b1;
            bus.busy_o     = 1'b1;
            state_d        = S_WAIT_LO;
         end

         S_WAIT_LO: begin
            bus.busy_o = 1'b1;
            // A done in the expiry cycle still counts as an answer
            if (bus.ed_done_i) begin
               state_d = S_START_HI;
            end else if (wd_expired) begin
               state_d = S_ERR;
            end
         end

         S_START_HI: begin
            bus.ed_start_o = 1'b1;
            bus.busy_o     = 1'b1;
            state_d        = S_WAIT_HI;
         end

         S_WAIT_HI: begin
            bus.busy_o = 1'b1;
            if (bus.ed_done_i) begin
               state_d = S_OUT;
            end else if (wd_expired) begin
               state_d = S_ERR;
            end
         end

         S_OUT: begin
            bus.out_valid_o = 1'b1;
            bus.busy_o      = 1'b1;
            if (bus.out_ready_i) begin
               state_d = S_IDLE;
            end
         end

         S_ERR: begin
            // Only rst_ni can clear this state
            bus.error_o = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: sampled byte/key/mode and the captured engine results
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hi_nib_q <= '0;
         code_q   <= '0;
         key_q    <= '0;
         mode_q   <= 1'b0;
         lo_res_q <= '0;
         hi_res_q <= '0;
      end else begin
         if (accept) begin
            // The low nibble goes straight to the engine code register,
            // so it is already on ed_code_o in START_LO
            code_q   <= bus.in_data_i[3:0];
            hi_nib_q <= bus.in_data_i[7:4];
            key_q    <= bus.key_i;
            mode_q   <= bus.mode_i;
         end
         if ((state_q == S_WAIT_LO) && bus.ed_done_i) begin
            lo_res_q <= bus.ed_code_i;
            code_q   <= hi_nib_q;
         end
         if ((state_q == S_WAIT_HI) && bus.ed_done_i) begin
            hi_res_q <= bus.ed_code_i;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Watchdog counter: cleared in each start cycle, counts through the wait
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_q <= '0;
      end else if (in_start) begin
         wd_q <= '0;
      end else if (in_wait) begin
         wd_q <= wd_q + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs. These stay unchanged until the next accept or done
   // event, so out_data_o stays stable for the whole OUT state.
   // ---------------------------------------------------------------------------
   assign bus.ed_code_o  = code_q;
   assign bus.ed_key_o   = key_q;
   assign bus.ed_mode_o  = mode_q;
   assign bus.out_data_o = {hi_res_q, lo_res_q};
   assign state_o        = state_q;

endmodule
